shift_unit_arbiter: RTL and testbench

//  Shares one combinational 64-bit shift datapath (SRL/SLL/SRA) between NREQ requesters.

---
 rtl/shift_unit_arbiter.sv | 127 ++++++++++++
 tb/tb_shift_unit_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: shares one 64-bit SRL/SLL/SRA datapath among NREQ requesters.
// Round-robin by default; define SHIFT_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
module shift_unit_arbiter #(
    parameter int DATA_W  = 64,
    parameter int SHAMT_W = 6,
    parameter int NREQ    = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*2-1:0]       req_op,
    input  logic [NREQ*DATA_W-1:0]  req_a,
    input  logic [NREQ*SHAMT_W-1:0] req_shamt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_result,
    output logic                    rsp_err
);

    typedef enum logic {IDLE, FULL} state_t;

    state_t              state;
    state_t              state_nx;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     gidx;
    logic                found;
    logic                can_accept;
    logic                accept;
    logic [2*NREQ-1:0]   rot;
    logic [1:0]          op;
    logic [DATA_W-1:0]   a;
    logic [SHAMT_W-1:0]  sh;
    logic [DATA_W-1:0]   res;
    logic                err;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + ID_W'(1);
        end
    end
`endif

    // Rotate so bit k of rot is requester (rr_ptr + k) mod NREQ.
    assign rot = {req_valid, req_valid} >> rr_ptr;

    always_comb begin : grant_p
        int j;
        j     = 0;
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && rot[k]) begin
                found = 1'b1;
                gidx  = ID_W'(j);
            end
        end
    end

    assign can_accept = (state == IDLE) | rsp_ready;
    assign accept     = can_accept & found;
    assign rsp_valid  = (state == FULL);

    always_comb begin
        req_ready = '0;
        op        = '0;
        a         = '0;
        sh        = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gidx == ID_W'(k)) begin
                op           = req_op[k*2 +: 2];
                a            = req_a[k*DATA_W +: DATA_W];
                sh           = req_shamt[k*SHAMT_W +: SHAMT_W];
                req_ready[k] = accept;
            end
        end
    end

    always_comb begin
        res = '0;
        err = 1'b0;
        unique case (op)
            2'b00:   res = a >> sh;
            2'b01:   res = a << sh;
            2'b10:   res = $unsigned($signed(a) >>> sh);
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = FULL;
            FULL: begin
                if (accept)         state_nx = FULL;
                else if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rsp_id     <= gidx;
                rsp_result <= res;
                rsp_err    <= err;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter: vector table + scoreboard bench for shift_unit_arbiter.
// Expected responses are queued at accept and checked at the response handshake.
module tb_shift_unit_arbiter;

    localparam int DW = 64;
    localparam int SW = 6;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_op;
    logic [N*DW-1:0] req_a;
    logic [N*SW-1:0] req_shamt;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_result;
    logic            rsp_err;

    shift_unit_arbiter #(.DATA_W(DW), .SHAMT_W(SW), .NREQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] res;
        logic          err;
    } rsp_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [SW-1:0] sh;
        logic [DW-1:0] exp_res;
        logic          exp_err;
    } vec_t;

    rsp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    logic          model_full;
    logic [IW-1:0] model_rr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [DW-1:0] a,
                           input logic [SW-1:0] sh);
        req_op[i*2 +: 2]     = op;
        req_a[i*DW +: DW]    = a;
        req_shamt[i*SW +: SW] = sh;
    endtask

    function automatic rsp_t model(input int g);
        rsp_t          r;
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [SW-1:0] s;
        op    = req_op[g*2 +: 2];
        a     = req_a[g*DW +: DW];
        s     = req_shamt[g*SW +: SW];
        r.id  = IW'(g);
        r.err = 1'b0;
        case (op)
            2'b00:   r.res = a >> s;
            2'b01:   r.res = a << s;
            2'b10:   r.res = $unsigned($signed(a) >>> s);
            default: begin r.res = '0; r.err = 1'b1; end
        endcase
        return r;
    endfunction

    function automatic int exp_grant();
        int g;
        int j;
        g = -1;
        for (int k = 0; k < N; k++) begin
            j = (int'(model_rr) + k) % N;
            if (g < 0 && req_valid[j]) g = j;
        end
        return g;
    endfunction

    // One clock: check handshakes at negedge, update model at posedge.
    task automatic tick(input logic use_ov, input rsp_t ov);
        int         g;
        rsp_t       e;
        logic [N-1:0] er;
        @(negedge clk);
        chk("rsp_valid", 64'(rsp_valid), 64'(model_full));
        g  = (!model_full || rsp_ready) ? exp_grant() : -1;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got response id %0d expected none", rsp_id);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
        if (g >= 0) sb.push_back(use_ov ? ov : model(g));
        @(posedge clk);
        if (g >= 0) begin
            model_full = 1'b1;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            model_rr = (g == N - 1) ? '0 : IW'(g + 1);
`endif
        end else if (rsp_ready) begin
            model_full = 1'b0;
        end
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_shamt = '0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        model_full = 1'b0;
        model_rr   = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t  vecs[9];
    rsp_t  none;
    rsp_t  ov;
    int    fair_seq[8];
    logic [IW-1:0] s_id;
    logic [DW-1:0] s_res;
    logic          s_err;

    initial begin
        none = '0;
        vecs[0] = '{2'd0, 2'b00, 64'hFF00000000000000, 6'd8,  64'h00FF000000000000, 1'b0};
        vecs[1] = '{2'd1, 2'b00, 64'h8000000000000000, 6'd63, 64'h0000000000000001, 1'b0};
        vecs[2] = '{2'd2, 2'b10, 64'h8000000000000000, 6'd63, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[3] = '{2'd3, 2'b01, 64'h0000000000000001, 6'd63, 64'h8000000000000000, 1'b0};
        vecs[4] = '{2'd0, 2'b00, 64'h123456789ABCDEF0, 6'd0,  64'h123456789ABCDEF0, 1'b0};
        vecs[5] = '{2'd1, 2'b10, 64'h7000000000000000, 6'd4,  64'h0700000000000000, 1'b0};
        vecs[6] = '{2'd2, 2'b11, 64'hFFFFFFFFFFFFFFFF, 6'd5,  64'h0000000000000000, 1'b1};
        vecs[7] = '{2'd3, 2'b01, 64'h00000000000000FF, 6'd60, 64'hF000000000000000, 1'b0};
        vecs[8] = '{2'd0, 2'b10, 64'hF000000000000000, 6'd4,  64'hFF00000000000000, 1'b0};
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        fair_seq = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        fair_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

        clear_reqs();
        rsp_ready = 1'b0;
        model_full = 1'b0;
        model_rr   = '0;
        #12;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_result", rsp_result, 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        do_reset();

        // Fairness: all requesters valid, consumer always ready.
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 2'b01, DW'(i + 1), SW'(i));
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, none);
            chk("fair_id", 64'(rsp_id), 64'(fair_seq[i]));
        end
        clear_reqs();
        tick(1'b0, none);

        // Vector table, back to back, each from a single requester.
        for (int i = 0; i < 9; i++) begin
            clear_reqs();
            set_req(int'(vecs[i].id), vecs[i].op, vecs[i].a, vecs[i].sh);
            req_valid[vecs[i].id] = 1'b1;
            ov.id  = vecs[i].id;
            ov.res = vecs[i].exp_res;
            ov.err = vecs[i].exp_err;
            tick(1'b1, ov);
        end
        clear_reqs();
        tick(1'b0, none);
        chk("drained", 64'(sb.size()), 64'd0);

        // Backpressure: slot held while rsp_ready is low.
        rsp_ready = 1'b0;
        set_req(0, 2'b00, 64'h5, 6'd1);
        req_valid = 4'b0001;
        tick(1'b0, none);
        clear_reqs();
        set_req(1, 2'b01, 64'h3, 6'd4);
        req_valid = 4'b0010;
        s_id  = rsp_id;
        s_res = rsp_result;
        s_err = rsp_err;
        chk("bp_first_result", s_res, 64'h2);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, none);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_stable", {s_res ^ rsp_result}, 64'd0);
            chk("bp_stable_id", 64'({s_id, s_err}), 64'({rsp_id, rsp_err}));
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'b0010);
        tick(1'b0, none);
        chk("bp_next_id", 64'(rsp_id), 64'd1);
        chk("bp_next_result", rsp_result, 64'h30);
        clear_reqs();
        tick(1'b0, none);

        // Reset mid-operation drops the held response.
        rsp_ready = 1'b0;
        set_req(1, 2'b00, 64'hF0, 6'd4);
        req_valid = 4'b0010;
        tick(1'b0, none);
        chk("mid_full", 64'(rsp_valid), 64'd1);
        clear_reqs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", 64'(rsp_valid), 64'd0);
        chk("mid_reset_result", rsp_result, 64'd0);
        model_full = 1'b0;
        model_rr   = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 2'b00, 64'h100, SW'(i));
        req_valid = '1;
        #1;
        chk("post_reset_grant", 64'(req_ready), 64'b0001);
        tick(1'b0, none);
        chk("post_reset_id", 64'(rsp_id), 64'd0);
        clear_reqs();
        tick(1'b0, none);
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
